// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: 4-beat miss refill FSM; CACHE_CRITICAL_WORD_FIRST_EN starts the burst at the requested word.
module cache_refill_ctrl #(
    parameter int DATA  = 32,
    parameter int WORDS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_i,
    input  logic [DATA-1:0] addr_i,
    input  logic            hit_i,
    output logic            stall_o,
    output logic            mem_req_o,
    output logic [DATA-1:0] mem_addr_o,
    input  logic            mem_ready_i,
    input  logic [DATA-1:0] mem_rdata_i,
    output logic            fill_we_o,
    output logic [DATA-1:0] fill_addr_o,
    output logic [DATA-1:0] fill_word0_o,
    output logic [DATA-1:0] fill_word1_o,
    output logic [DATA-1:0] fill_word2_o,
    output logic [DATA-1:0] fill_word3_o
);
    typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;
    state_t                     r_state, w_next;
    logic [DATA-5:0]            r_blk;
    logic [1:0]                 r_off;
    logic [2:0]                 r_cnt;
    logic [WORDS-1:0][DATA-1:0] r_buf;
    logic                       w_miss;
    logic [1:0]                 w_start, w_idx;
    logic                       w_unused;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    assign w_start = r_off;
`else
    assign w_start = 2'b00;
`endif
    assign w_unused = &{1'b0, addr_i[1:0], r_off};
    assign w_miss   = req_i && !hit_i;
    assign w_idx    = w_start + r_cnt[1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_blk   <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_miss) begin
                r_blk <= addr_i[DATA-1:4];
                r_off <= addr_i[3:2];
                r_cnt <= '0;
            end else if (r_state == FETCH && mem_ready_i) begin
                r_buf[w_idx] <= mem_rdata_i;
                r_cnt        <= r_cnt + 3'd1;
            end
        end
    end
    always_comb begin
        w_next = IDLE;
        w_next = r_state == IDLE  ? (w_miss ? FETCH : IDLE) :
                 r_state == FETCH ? ((mem_ready_i && r_cnt == 3'd3) ? FILL : FETCH) : IDLE;
    end
    // stall is gated by rst_n so a miss seen during reset never freezes the pipeline
    assign stall_o      = rst_n && (r_state == IDLE ? w_miss : 1'b1);
    assign mem_req_o    = r_state == FETCH;
    assign mem_addr_o   = {r_blk, w_idx, 2'b00};
    assign fill_we_o    = r_state == FILL;
    assign fill_addr_o  = {r_blk, 4'b0000};
    assign fill_word0_o = r_buf[0];
    assign fill_word1_o = r_buf[1];
    assign fill_word2_o = r_buf[2];
    assign fill_word3_o = r_buf[3];
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized refill scenarios checked against a beat-order/word-buffer model.
module tb_cache_refill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        hit_i = 1'b0;
    logic        stall_o, mem_req_o, fill_we_o;
    logic [31:0] mem_addr_o, fill_addr_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] fill_word0_o, fill_word1_o, fill_word2_o, fill_word3_o;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_w [4];
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    cache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .hit_i(hit_i),
        .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .fill_we_o(fill_we_o),
        .fill_addr_o(fill_addr_o), .fill_word0_o(fill_word0_o), .fill_word1_o(fill_word1_o),
        .fill_word2_o(fill_word2_o), .fill_word3_o(fill_word3_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int start_of(input logic [31:0] a);
        return CWF ? int'(a[3:2]) : 0;
    endfunction

    // Assumes DUT idle at posedge+1; returns at posedge+1 of the cycle after FILL.
    task automatic do_refill(input logic [31:0] a, input int mode);
        int k, c, idx;
        logic r;
        logic [31:0] ea;
        req_i = 1'b1; hit_i = 1'b0; addr_i = a; mem_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0 || fill_we_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_miss: stall_o=%b mem_req_o=%b fill_we_o=%b, need 1 0 0", stall_o, mem_req_o, fill_we_o);
        end
        @(posedge clk); #1;
        k = 0; c = 1;
        while (k < 4 && c < 60) begin
            req_i = 1'($urandom_range(0, 1)); hit_i = 1'($urandom_range(0, 1)); addr_i = $urandom;
            r = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            mem_ready_i = r;
            mem_rdata_i = mode == 0 ? 32'hA0 + 32'(k) : $urandom;
            idx = (start_of(a) + k) % 4;
            ea = (a & ~32'hF) + 32'(idx * 4);
            @(negedge clk);
            checks++;
            if (mem_req_o !== 1'b1 || stall_o !== 1'b1 || fill_we_o !== 1'b0 || mem_addr_o !== ea) begin
                errors++;
                $display("FAIL fetch beat %0d cyc %0d: mem_addr_o=%h need %h, mem_req_o=%b stall_o=%b fill_we_o=%b need 1 1 0",
                         k, c, mem_addr_o, ea, mem_req_o, stall_o, fill_we_o);
            end
            if (r) begin
                exp_w[idx] = mem_rdata_i;
                k++;
            end
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (k < 4) begin
            errors++;
            $display("FAIL fetch_timeout: %0d beats accepted, need 4", k);
        end
        req_i = 1'b0; mem_ready_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
        @(negedge clk);
        checks++;
        if (fill_we_o !== 1'b1 || stall_o !== 1'b1 || mem_req_o !== 1'b0 || fill_addr_o !== (a & ~32'hF)) begin
            errors++;
            $display("FAIL fill: fill_we_o=%b stall_o=%b mem_req_o=%b fill_addr_o=%h, need 1 1 0 %h",
                     fill_we_o, stall_o, mem_req_o, fill_addr_o, a & ~32'hF);
        end
        checks++;
        if ({fill_word3_o, fill_word2_o, fill_word1_o, fill_word0_o} !== {exp_w[3], exp_w[2], exp_w[1], exp_w[0]}) begin
            errors++;
            $display("FAIL fill_words: got %h %h %h %h need %h %h %h %h", fill_word3_o, fill_word2_o, fill_word1_o,
                     fill_word0_o, exp_w[3], exp_w[2], exp_w[1], exp_w[0]);
        end
        if (mode == 0) begin
            checks++;
            if (c != 5) begin
                errors++;
                $display("FAIL fill_latency: fill at cycle %0d, need 5", c);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req_i = 1'b1; hit_i = 1'b0; addr_i = 32'h40; mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) exp_w[i] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall_o, mem_req_o, fill_we_o} !== 3'b000 || fill_addr_o !== '0 ||
            {fill_word3_o, fill_word2_o, fill_word1_o, fill_word0_o} !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b mem_req=%b fill_we=%b fill_addr=%h w0=%h, need all 0",
                     stall_o, mem_req_o, fill_we_o, fill_addr_o, fill_word0_o);
        end
        @(posedge clk); #1;
        req_i = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({stall_o, mem_req_o, fill_we_o} !== 3'b000) begin
                errors++;
                $display("FAIL reset_quiet cyc %0d: stall=%b mem_req=%b fill_we=%b, need 0 0 0", i, stall_o, mem_req_o, fill_we_o);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_refill(32'h0000_0040, 0);
        req_i = 1'b1; hit_i = 1'b1; addr_i = 32'h40;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || fill_we_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_cycle6: stall=%b fill_we=%b mem_req=%b, need 0 0 0", stall_o, fill_we_o, mem_req_o);
        end
        checks++;
        if ({fill_word3_o, fill_word2_o, fill_word1_o, fill_word0_o} !== {32'hA3, 32'hA2, 32'hA1, 32'hA0} ||
            fill_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL basic_words: got %h %h %h %h addr %h, need a3 a2 a1 a0 addr 40",
                     fill_word3_o, fill_word2_o, fill_word1_o, fill_word0_o, fill_addr_o);
        end
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    task automatic test_critical_word();
        do_refill(32'h0000_0038, 2);
    endtask

    task automatic test_slow_memory();
        do_refill(32'h0000_0100, 1);
    endtask

    task automatic test_back_to_back();
        do_refill($urandom, 2);
        do_refill($urandom, 0);
        do_refill($urandom, 1);
    endtask

    task automatic test_hits();
        for (int i = 0; i < 20; i++) begin
            req_i = 1'b1; hit_i = 1'b1; addr_i = $urandom;
            mem_ready_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
            @(negedge clk);
            checks++;
            if ({stall_o, mem_req_o, fill_we_o} !== 3'b000) begin
                errors++;
                $display("FAIL hits cyc %0d: stall=%b mem_req=%b fill_we=%b, need 0 0 0", i, stall_o, mem_req_o, fill_we_o);
            end
            @(posedge clk); #1;
        end
        req_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({fill_word3_o, fill_word2_o, fill_word1_o, fill_word0_o} !== {exp_w[3], exp_w[2], exp_w[1], exp_w[0]}) begin
            errors++;
            $display("FAIL hits_hold: words changed to %h %h %h %h", fill_word3_o, fill_word2_o, fill_word1_o, fill_word0_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] a;
        logic [31:0] ea;
        a = $urandom;
        req_i = 1'b1; hit_i = 1'b0; addr_i = a; mem_ready_i = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b0; mem_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mem_rdata_i = $urandom;
            ea = (a & ~32'hF) + 32'(((start_of(a) + k) % 4) * 4);
            @(negedge clk);
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== ea) begin
                errors++;
                $display("FAIL rstmid_beat %0d: mem_req=%b mem_addr=%h, need 1 %h", k, mem_req_o, mem_addr_o, ea);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) exp_w[i] = '0;
        checks++;
        if ({stall_o, mem_req_o, fill_we_o} !== 3'b000 || fill_addr_o !== '0 ||
            {fill_word3_o, fill_word2_o, fill_word1_o, fill_word0_o} !== 128'h0) begin
            errors++;
            $display("FAIL rstmid_async: stall=%b mem_req=%b fill_we=%b fill_addr=%h w0=%h, need all 0",
                     stall_o, mem_req_o, fill_we_o, fill_addr_o, fill_word0_o);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            mem_ready_i = 1'b1;
            @(negedge clk);
            checks++;
            if (fill_we_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_fill cyc %0d: fill_we=%b mem_req=%b, need 0 0", i, fill_we_o, mem_req_o);
            end
            @(posedge clk); #1;
        end
        do_refill(a, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_critical_word();
        test_slow_memory();
        test_hits();
        test_back_to_back();
        test_reset_mid_fetch();
        test_hits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter: DATA, 32, data and address width in bits.
REQ-002 Parameter: WORDS, 4, words per cache block; fixed at 4, and other values are unsupported.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_i  input  1  CPU data access valid this cycle.
REQ-006 addr_i  input  DATA  CPU byte address; [DATA-1:4] block, [3:2] word offset.
REQ-007 hit_i  input  1  cache hit for addr_i, combinational from cache.
REQ-008 stall_o  output  1  pipeline freeze.
REQ-009 mem_req_o  output  1  main-memory word request.
REQ-010 mem_addr_o  output  DATA  word-aligned address of the current beat.
REQ-011 mem_ready_i  input  1  memory returns mem_rdata_i this cycle.
REQ-012 mem_rdata_i  input  DATA  returned word.
REQ-013 fill_we_o  output  1  one-cycle cache overwrite strobe.
REQ-014 fill_addr_o  output  DATA  block-aligned address of the filled block, with [3:0]=0.
REQ-015 fill_word0_o..fill_word3_o  output  DATA each  refill buffer, where word n is the block word at offset n.

Function
REQ-016 FSM states SHALL be IDLE, FETCH and FILL.
REQ-017 IDLE: req_i && !hit_i SHALL latch addr_i[DATA-1:4] and addr_i[3:2], clear the beat count, and enter FETCH next edge.
REQ-018 IDLE: stall_o SHALL equal req_i && !hit_i, combinationally.
REQ-019 FETCH: mem_req_o=1, stall_o=1; mem_addr_o = {latched block, beat index, 2'b00}, held stable until mem_ready_i.
REQ-020 FETCH: on mem_ready_i, mem_rdata_i SHALL be written to buffer word[beat index] and the beat count incremented.
REQ-021 FETCH: the beat count SHALL be 3 bits and count 0..4; the beat index SHALL be (start offset + count) mod 4, wrapping 3->0.
REQ-022 FETCH: on the 4th accepted beat, the FSM SHALL enter FILL; mem_ready_i without mem_req_o SHALL be ignored.
REQ-023 FILL: fill_we_o=1 and stall_o=1 for exactly one cycle, then return to IDLE.
REQ-024 fill_addr_o and fill_word*_o SHALL hold their values until the next miss overwrites them.
REQ-025 Latency: with mem_ready_i tied high and a miss at cycle 0, beats are at cycles 1-4, fill_we_o is at cycle 5, and stall_o is low at cycle 6 when hit_i=1.
REQ-026 req_i and addr_i changes during FETCH or FILL SHALL be ignored.
REQ-027 A miss presented in the cycle after FILL SHALL start a new refill as in IDLE.
REQ-028 fill_we_o and mem_req_o SHALL never be high in the same cycle.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, with mem_req_o=0, fill_we_o=0, beat count 0, latched block and offset 0, fill_addr_o=0 and all fill_word*_o=0.
REQ-030 While rst_n is low, stall_o SHALL be 0.
REQ-031 Reset during FETCH SHALL discard partial data, and no fill_we_o SHALL follow.

Configuration
REQ-032 Macro CACHE_CRITICAL_WORD_FIRST_EN defined: the start offset SHALL be the latched addr_i[3:2], so the beat order wraps from the requested word.
REQ-033 Macro CACHE_CRITICAL_WORD_FIRST_EN undefined: the start offset SHALL be 0, giving beat order 0,1,2,3; the port list is identical in both cases.

Verification
REQ-034 Reset -> all outputs 0, state IDLE; assert rst_n -> no activity with req_i=0.
REQ-035 Miss at addr 0x0000_0040, mem_ready_i=1, mem_rdata_i = 0xA0+beat -> mem_addr_o 0x40,0x44,0x48,0x4C; fill_we_o at cycle 5; fill_addr_o=0x40; words 0xA0..0xA3; stall_o low at cycle 6.
REQ-036 CACHE_CRITICAL_WORD_FIRST_EN defined, miss at 0x0000_0038 -> mem_addr_o 0x38,0x3C,0x30,0x34; fill_word2_o gets the first beat; fill_addr_o=0x30.
REQ-037 Miss at 0x100, mem_ready_i high only every 3rd cycle -> mem_addr_o stable between accepts; fill_we_o one cycle after the 4th accept; addr_i changes mid-fetch are ignored.
REQ-038 rst_n pulsed low after the 2nd beat -> mem_req_o drops immediately; no fill_we_o; the next miss restarts at beat 0.
REQ-039 req_i=1, hit_i=1 continuously -> stall_o=0, mem_req_o=0, fill_we_o=0 throughout.
